// File: rtl/axi_lite_arbiter.sv
// axi_lite_arbiter: round-robin arbiter passing one AXI-Lite transaction at a time from two masters to one slave port.
module axi_lite_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   m0_awaddr,
  input  logic                    m0_awvalid,
  output logic                    m0_awready,
  input  logic [DATA_WIDTH-1:0]   m0_wdata,
  input  logic [DATA_WIDTH/8-1:0] m0_wmask,
  input  logic                    m0_wvalid,
  output logic                    m0_wready,
  output logic [1:0]              m0_bresp,
  output logic                    m0_bvalid,
  input  logic                    m0_bready,
  input  logic [ADDR_WIDTH-1:0]   m0_araddr,
  input  logic                    m0_arvalid,
  output logic                    m0_arready,
  output logic [DATA_WIDTH-1:0]   m0_rdata,
  output logic [1:0]              m0_rresp,
  output logic                    m0_rvalid,
  input  logic                    m0_rready,
  input  logic [ADDR_WIDTH-1:0]   m1_awaddr,
  input  logic                    m1_awvalid,
  output logic                    m1_awready,
  input  logic [DATA_WIDTH-1:0]   m1_wdata,
  input  logic [DATA_WIDTH/8-1:0] m1_wmask,
  input  logic                    m1_wvalid,
  output logic                    m1_wready,
  output logic [1:0]              m1_bresp,
  output logic                    m1_bvalid,
  input  logic                    m1_bready,
  input  logic [ADDR_WIDTH-1:0]   m1_araddr,
  input  logic                    m1_arvalid,
  output logic                    m1_arready,
  output logic [DATA_WIDTH-1:0]   m1_rdata,
  output logic [1:0]              m1_rresp,
  output logic                    m1_rvalid,
  input  logic                    m1_rready,
  output logic [ADDR_WIDTH-1:0]   s_awaddr,
  output logic                    s_awvalid,
  input  logic                    s_awready,
  output logic [DATA_WIDTH-1:0]   s_wdata,
  output logic [DATA_WIDTH/8-1:0] s_wmask,
  output logic                    s_wvalid,
  input  logic                    s_wready,
  input  logic [1:0]              s_bresp,
  input  logic                    s_bvalid,
  output logic                    s_bready,
  output logic [ADDR_WIDTH-1:0]   s_araddr,
  output logic                    s_arvalid,
  input  logic                    s_arready,
  input  logic [DATA_WIDTH-1:0]   s_rdata,
  input  logic [1:0]              s_rresp,
  input  logic                    s_rvalid,
  output logic                    s_rready
);
  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP} state_t;
  state_t state, state_nxt;
  logic grant, last_grant, aw_done, w_done;
  logic req0, req1, win, aw_hs, w_hs, leave_wr;
  logic [ADDR_WIDTH-1:0] g_araddr, g_awaddr;
  logic [DATA_WIDTH-1:0] g_wdata, u_rdata;
  logic [DATA_WIDTH/8-1:0] g_wmask;
  logic g_arvalid, g_awvalid, g_wvalid, g_rready, g_bready;
  logic u_arready, u_awready, u_wready, u_rvalid, u_bvalid;
  logic [1:0] u_rresp, u_bresp;
  assign g_araddr  = grant ? m1_araddr  : m0_araddr;
  assign g_arvalid = grant ? m1_arvalid : m0_arvalid;
  assign g_awaddr  = grant ? m1_awaddr  : m0_awaddr;
  assign g_awvalid = grant ? m1_awvalid : m0_awvalid;
  assign g_wdata   = grant ? m1_wdata   : m0_wdata;
  assign g_wmask   = grant ? m1_wmask   : m0_wmask;
  assign g_wvalid  = grant ? m1_wvalid  : m0_wvalid;
  assign g_rready  = grant ? m1_rready  : m0_rready;
  assign g_bready  = grant ? m1_bready  : m0_bready;
  assign req0 = m0_arvalid | m0_awvalid;
  assign req1 = m1_arvalid | m1_awvalid;
  assign win  = (req0 & req1) ? ~last_grant : req1;
  assign aw_hs = s_awvalid & s_awready;
  assign w_hs  = s_wvalid & s_wready;
  assign leave_wr = (state == WR_REQ) & (aw_done | aw_hs) & (w_done | w_hs);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && (req0 | req1)) begin
        grant      <= win;
        last_grant <= win;
      end
      aw_done <= (state == WR_REQ) & ~leave_wr & (aw_done | aw_hs);
      w_done  <= (state == WR_REQ) & ~leave_wr & (w_done | w_hs);
    end
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req0 | req1) state_nxt = (win ? m1_arvalid : m0_arvalid) ? RD_ADDR : WR_REQ;
      RD_ADDR: if (g_arvalid & s_arready) state_nxt = RD_DATA;
      RD_DATA: if (s_rvalid & g_rready) state_nxt = IDLE;
      WR_REQ:  if (leave_wr) state_nxt = WR_RESP;
      WR_RESP: if (s_bvalid & g_bready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  // Completed write channels are masked both ways until the state leaves WR_REQ.
  always_comb begin
    s_arvalid = (state == RD_ADDR) & g_arvalid;
    s_araddr  = s_arvalid ? g_araddr : '0;
    s_rready  = (state == RD_DATA) & g_rready;
    s_awvalid = (state == WR_REQ) & ~aw_done & g_awvalid;
    s_awaddr  = s_awvalid ? g_awaddr : '0;
    s_wvalid  = (state == WR_REQ) & ~w_done & g_wvalid;
    s_wdata   = s_wvalid ? g_wdata : '0;
    s_wmask   = s_wvalid ? g_wmask : '0;
    s_bready  = (state == WR_RESP) & g_bready;
    u_arready = (state == RD_ADDR) & s_arready;
    u_rvalid  = (state == RD_DATA) & s_rvalid;
    u_rdata   = (state == RD_DATA) ? s_rdata : '0;
    u_rresp   = (state == RD_DATA) ? s_rresp : 2'b00;
    u_awready = (state == WR_REQ) & ~aw_done & s_awready;
    u_wready  = (state == WR_REQ) & ~w_done & s_wready;
    u_bvalid  = (state == WR_RESP) & s_bvalid;
    u_bresp   = (state == WR_RESP) ? s_bresp : 2'b00;
    m0_arready = ~grant & u_arready;
    m0_rvalid  = ~grant & u_rvalid;
    m0_rdata   = grant ? '0 : u_rdata;
    m0_rresp   = grant ? 2'b00 : u_rresp;
    m0_awready = ~grant & u_awready;
    m0_wready  = ~grant & u_wready;
    m0_bvalid  = ~grant & u_bvalid;
    m0_bresp   = grant ? 2'b00 : u_bresp;
    m1_arready = grant & u_arready;
    m1_rvalid  = grant & u_rvalid;
    m1_rdata   = grant ? u_rdata : '0;
    m1_rresp   = grant ? u_rresp : 2'b00;
    m1_awready = grant & u_awready;
    m1_wready  = grant & u_wready;
    m1_bvalid  = grant & u_bvalid;
    m1_bresp   = grant ? u_bresp : 2'b00;
  end
endmodule

// File: tb/tb_axi_lite_arbiter.sv
// tb_axi_lite_arbiter: directed checks of arbitration, read/write forwarding and reset behaviour.
module tb_axi_lite_arbiter;
  logic clk = 0, reset = 0;
  logic [31:0] m0_awaddr, m0_wdata, m0_araddr, m0_rdata, m1_awaddr, m1_wdata, m1_araddr, m1_rdata;
  logic [3:0] m0_wmask, m1_wmask, s_wmask;
  logic m0_awvalid, m0_awready, m0_wvalid, m0_wready, m0_bvalid, m0_bready, m0_arvalid, m0_arready, m0_rvalid, m0_rready;
  logic m1_awvalid, m1_awready, m1_wvalid, m1_wready, m1_bvalid, m1_bready, m1_arvalid, m1_arready, m1_rvalid, m1_rready;
  logic [1:0] m0_bresp, m0_rresp, m1_bresp, m1_rresp, s_bresp, s_rresp;
  logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
  logic s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready, s_arvalid, s_arready, s_rvalid, s_rready;
  int tests = 0, failed = 0;
  always #5 clk = ~clk;
  axi_lite_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_awaddr(m0_awaddr), .m0_awvalid(m0_awvalid), .m0_awready(m0_awready),
    .m0_wdata(m0_wdata), .m0_wmask(m0_wmask), .m0_wvalid(m0_wvalid), .m0_wready(m0_wready),
    .m0_bresp(m0_bresp), .m0_bvalid(m0_bvalid), .m0_bready(m0_bready),
    .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
    .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
    .m1_awaddr(m1_awaddr), .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
    .m1_wdata(m1_wdata), .m1_wmask(m1_wmask), .m1_wvalid(m1_wvalid), .m1_wready(m1_wready),
    .m1_bresp(m1_bresp), .m1_bvalid(m1_bvalid), .m1_bready(m1_bready),
    .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
    .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wmask(s_wmask), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    {m0_awaddr, m0_wdata, m0_araddr, m1_awaddr, m1_wdata, m1_araddr} = '0;
    {m0_wmask, m1_wmask} = '0;
    {m0_awvalid, m0_wvalid, m0_bready, m0_arvalid, m0_rready} = '0;
    {m1_awvalid, m1_wvalid, m1_bready, m1_arvalid, m1_rready} = '0;
    {s_awready, s_wready, s_bvalid, s_arready, s_rvalid} = '0;
    {s_bresp, s_rresp} = '0;
    s_rdata = '0;
    m0_arvalid = 1; m1_awvalid = 1; s_rvalid = 1; s_arready = 1;
    repeat (2) tick();
    chk("rst_s_valids", {s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready}, 0);
    chk("rst_m_readys", {m0_arready, m0_rvalid, m1_awready, m1_wready, m1_bvalid}, 0);
    m0_arvalid = 0; m1_awvalid = 0; s_rvalid = 0;
    reset = 1;
    // Both masters read at once: m0 wins the first tie.
    m0_arvalid = 1; m0_araddr = 32'h100; m1_arvalid = 1; m1_araddr = 32'h200;
    #1 chk("idle_latency", {s_arvalid, m0_arready, m1_arready}, 0);
    tick();
    chk("t1_araddr", s_araddr, 32'h100);
    chk("t1_rdy", {s_arvalid, m0_arready, m1_arready}, 3'b110);
    tick();
    m0_arvalid = 0; s_rvalid = 1; s_rdata = 32'h12345678; m0_rready = 1; m1_rready = 1;
    #1 chk("t1_m0_rdata", m0_rdata, 32'h12345678);
    chk("t1_rvalid", {m0_rvalid, m1_rvalid, s_rready, s_arvalid}, 4'b1010);
    chk("t1_m1_rdata", m1_rdata, 0);
    tick();
    s_rvalid = 0;
    #1 chk("t1_back_idle", {s_arvalid, m1_arready}, 0);
    tick();
    chk("t1_m1_araddr", {s_araddr, m1_arready, m0_arready}, {32'h200, 2'b10});
    tick();
    m1_arvalid = 0; s_rvalid = 1; s_rdata = 32'hcafe; s_rresp = 2'b10;
    #1 chk("t1_m1_read", {m1_rdata, m1_rresp, m1_rvalid, m0_rvalid}, {32'hcafe, 2'b10, 2'b10});
    tick();
    s_rvalid = 0; s_rresp = 0;
    // m1 write: w accepted in cycle 1, aw held off until cycle 3.
    m1_awvalid = 1; m1_awaddr = 32'ha00003f8; m1_wvalid = 1; m1_wdata = 32'h41; m1_wmask = 4'h1;
    m1_bready = 1; s_awready = 0; s_wready = 1;
    tick();
    chk("t2_c1_aw", {s_awaddr, s_awvalid, m1_awready}, {32'ha00003f8, 2'b10});
    chk("t2_c1_w", {s_wdata, s_wmask, s_wvalid, m1_wready}, {32'h41, 4'h1, 2'b11});
    tick();
    chk("t2_c2_w_masked", {s_wdata, s_wmask, s_wvalid, m1_wready, s_awvalid}, {32'h0, 4'h0, 3'b001});
    tick();
    s_awready = 1;
    #1 chk("t2_c3_aw", {m1_awready, s_awvalid, s_wvalid}, 3'b110);
    tick();
    m1_awvalid = 0; m1_wvalid = 0; s_bvalid = 1; s_bresp = 2'b00;
    #1 chk("t2_resp", {m1_bvalid, m1_bresp, m0_bvalid, s_bready, s_awvalid}, 6'b100010);
    tick();
    s_bvalid = 0;
    // m1 read and write together: read first.
    m1_arvalid = 1; m1_araddr = 32'h300; m1_awvalid = 1; m1_awaddr = 32'h400;
    m1_wvalid = 1; m1_wdata = 32'h55; m1_wmask = 4'hf;
    tick();
    chk("t3_read_first", {s_arvalid, s_awvalid, s_araddr}, {2'b10, 32'h300});
    tick();
    m1_arvalid = 0; s_rvalid = 1; s_rdata = 32'h77;
    #1 chk("t3_rdata", {m1_rdata, m1_rvalid}, {32'h77, 1'b1});
    tick();
    s_rvalid = 0;
    tick();
    chk("t3_write_next", {s_awvalid, s_wvalid, s_awaddr, s_wdata}, {2'b11, 32'h400, 32'h55});
    tick();
    m1_awvalid = 0; m1_wvalid = 0; s_bvalid = 1; s_bresp = 2'b10;
    #1 chk("t3_bresp", {m1_bvalid, m1_bresp}, 3'b110);
    tick();
    s_bvalid = 0; s_bresp = 0;
    // Sustained requests alternate grants.
    m0_arvalid = 1; m1_arvalid = 1; s_rvalid = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("rr_%0d", i), {m0_arready, m1_arready}, (i % 2 == 0) ? 2'b10 : 2'b01);
      tick();
      tick();
    end
    // Stalled read from m1 while m0 requests.
    s_rvalid = 0; m0_arvalid = 0;
    tick();
    tick();
    m0_arvalid = 1; m1_arvalid = 0;
    for (int i = 0; i < 10; i++) begin
      #1 chk($sformatf("stall_%0d", i), {m0_arready, s_arvalid, m1_rvalid}, 0);
      tick();
    end
    s_rvalid = 1;
    #1 chk("stall_done", m1_rvalid, 1'b1);
    tick();
    s_rvalid = 0;
    tick();
    chk("stall_m0_grant", {m0_arready, s_araddr}, {1'b1, 32'h100});
    tick();
    m0_arvalid = 0;
    #1 chk("rd_data_rready", s_rready, 1'b1);
    // Async reset in RD_DATA abandons the read.
    #2 reset = 0;
    s_rvalid = 1;
    #1 chk("async_rst_out", {s_rready, m0_rvalid, s_arvalid, m0_arready}, 0);
    tick();
    reset = 1; s_rvalid = 0;
    m0_arvalid = 1; m1_arvalid = 1;
    #1 chk("post_rst_idle", {s_arvalid, m0_arready, m1_arready}, 0);
    tick();
    chk("post_rst_tie", {m0_arready, m1_arready}, 2'b10);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/axi_lite_arbiter.md
AXI_LITE_ARBITER -- requirements
Module: axi_lite_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, address width of all ports.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width of all ports; wmask width DATA_WIDTH/8.
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-005 SHALL have port m0  axi_lite_if.slave  bundle  upstream master 0 (instruction fetch).
REQ-006 SHALL have port m1  axi_lite_if.slave  bundle  upstream master 1 (load/store unit).
REQ-007 SHALL have port s  axi_lite_if.master  bundle  downstream port feeding the address-decoding crossbar.

Function
REQ-008 SHALL pass exactly one transaction, read or write, at a time, from one granted master.
REQ-009 SHALL implement states IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP.
REQ-010 A master SHALL be requesting in IDLE when its arvalid or awvalid is 1.
REQ-011 Arbitration SHALL be round-robin: if both request, the grant goes to the master not in last_grant; if one requests, it wins.
REQ-012 On a grant in IDLE, grant and last_grant SHALL register the winner. Next state is RD_ADDR if the winner's arvalid=1 (reads take precedence over writes from the same master), otherwise WR_REQ.
REQ-013 Arbitration latency SHALL be 1 cycle: in IDLE all s.*valid and all m*.*ready outputs are 0.
REQ-014 In RD_ADDR: s.arvalid = granted arvalid, s.araddr = granted araddr, granted arready = s.arready. On the ar handshake, go to RD_DATA.
REQ-015 In RD_DATA: granted rvalid/rdata/rresp = s.rvalid/rdata/rresp, s.rready = granted rready. On the r handshake, go to IDLE.
REQ-016 In WR_REQ: aw and w channels of the granted master are forwarded independently. Sticky flags aw_done and w_done are set on each handshake. The valid of a completed channel is forced to 0 downstream, and its ready to 0 upstream.
REQ-017 WR_REQ SHALL go to WR_RESP in the cycle both handshakes are complete, whether they complete in the same cycle or in different cycles. Both flags clear on leaving.
REQ-018 In WR_RESP: granted bvalid/bresp = s.bvalid/bresp, s.bready = granted bready. On the b handshake, go to IDLE.
REQ-019 For the non-granted master: arready, awready, wready, rvalid and bvalid SHALL be 0; rdata and rresp SHALL be 0; bresp SHALL be 0.
REQ-020 Downstream address and data outputs SHALL be 0 when the corresponding valid is 0.
REQ-021 A response handshake and a new request in the same cycle SHALL return to IDLE first; there is no back-to-back grant bypass.
REQ-022 A master that deasserts its request while not granted SHALL simply lose eligibility; no state is kept for it.
REQ-023 rresp and bresp SHALL be passed through unmodified; errors are not interpreted.

Reset
REQ-024 Reset SHALL force state=IDLE, grant=0, last_grant=1 (master 0 wins the first tie), aw_done=0 and w_done=0.
REQ-025 During reset all valid/ready outputs on every port SHALL be 0.
REQ-026 Reset asserted mid-transaction SHALL abandon the transaction immediately, with no completion signalled upstream.

Verification
REQ-027 Both masters assert arvalid in the same cycle after reset -> m0 is served first (RD_ADDR then RD_DATA, rdata 0x12345678 delivered to m0 only), then m1, with m1 seeing rvalid=0 throughout m0's read.
REQ-028 m1 issues a write: awaddr 0xa00003f8, wdata 0x41, wmask 0x1; s.awready is held until cycle 3 and s.wready is asserted in cycle 1 -> w is forwarded once, aw completes in cycle 3, WR_RESP is entered, and m1 receives bvalid with bresp 0.
REQ-029 m1 asserts arvalid and awvalid together -> the read is performed first, then the write on the next grant.
REQ-030 Sustained requests from both masters for 6 transactions -> grants alternate m0, m1, m0, m1, m0, m1.
REQ-031 reset asserted during RD_DATA with s.rvalid=0 -> outputs are 0 asynchronously; after release the state is IDLE and m0 wins the next tie.
REQ-032 s.rvalid held 0 for 10 cycles in RD_DATA while m0 requests -> m0 is never granted, and its arready stays 0, until the read completes.
